// File: rtl/id_pkg.sv
// Shared decode-stage definitions: MIPS opcode/funct encodings and the
// instruction-queue entry layout.
package id_pkg;

  localparam int IQ_XLEN = 32;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;

  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;

  typedef struct packed {
    logic [IQ_XLEN-1:0] instr;
    logic [IQ_XLEN-1:0] pc;
    logic               is_ds;
    logic               is_br;
  } iq_entry_t;

endpackage

// File: rtl/id_branch_predecode.sv
// Combinational branch/jump classifier on a raw instruction word.
module id_branch_predecode
  import id_pkg::*;
(
  input  logic [31:0] instr,
  output logic        is_br
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_bits;

  assign opcode      = instr[31:26];
  assign funct       = instr[5:0];
  assign unused_bits = ^instr[25:6];

  always_comb begin
    is_br = 1'b0;
    case (opcode)
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ,
      OP_REGIMM, OP_J, OP_JAL:             is_br = 1'b1;
      OP_SPECIAL: is_br = (funct == FN_JR) || (funct == FN_JALR);
      default:                             is_br = 1'b0;
    endcase
  end

endmodule

// File: rtl/id_instr_queue.sv
// IF/ID instruction queue: circular buffer tagging each entry with PC,
// branch predecode and delay-slot flag; flushed on exception/ERET.
module id_instr_queue
  import id_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_instr,
  input  logic [XLEN-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_instr,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_pc_plus_8,
  output logic              out_is_ds,
  output logic              out_is_branch,
  input  logic              flush,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

  iq_entry_t         mem_q [DEPTH];
  iq_entry_t         wr_entry;
  iq_entry_t         head;
  logic              wr_en;

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q,  count_d;
  logic              last_br_q, last_br_d;

  logic              in_is_br;
  logic              enq_fire;
  logic              deq_fire;

  id_branch_predecode u_predecode (
    .instr (in_instr[31:0]),
    .is_br (in_is_br)
  );

  assign in_ready  = (count_q != FULL_COUNT);
  assign out_valid = (count_q != '0);
  assign enq_fire  = in_valid && in_ready;
  assign deq_fire  = out_valid && out_ready;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    last_br_d = last_br_q;
    wr_en     = 1'b0;
    wr_entry  = '{instr: in_instr, pc: in_pc, is_ds: last_br_q, is_br: in_is_br};
    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      last_br_d = 1'b0;
    end else begin
      if (enq_fire) begin
        wr_en     = 1'b1;
        wr_ptr_d  = wr_ptr_q + 1'b1;
        last_br_d = in_is_br;
      end
      if (deq_fire) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({enq_fire, deq_fire})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      last_br_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      last_br_q <= last_br_d;
    end
  end

  // Storage is deliberately left unreset; flags below are gated by out_valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  assign head          = mem_q[rd_ptr_q];
  assign out_instr     = head.instr;
  assign out_pc        = head.pc;
  assign out_pc_plus_8 = head.pc + XLEN'(8);
  assign out_is_ds     = out_valid && head.is_ds;
  assign out_is_branch = out_valid && head.is_br;
  assign count         = count_q;

endmodule

// File: tb/tb_id_instr_queue.sv
// Directed self-checking bench for id_instr_queue (DEPTH=4, XLEN=32).
module tb_id_instr_queue;

  localparam logic [31:0] I_BEQ  = 32'h1022_0003;
  localparam logic [31:0] I_ADDU = 32'h0022_1821;
  localparam logic [31:0] I_J    = 32'h0800_0000;
  localparam logic [31:0] I_JAL  = 32'h0C00_0000;
  localparam logic [31:0] I_JR   = 32'h03E0_0008;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus_8;
  logic        out_is_ds;
  logic        out_is_branch;
  logic        flush = 1'b0;
  logic [2:0]  count;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  id_instr_queue #(.DEPTH(4), .XLEN(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .in_pc         (in_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .out_pc_plus_8 (out_pc_plus_8),
    .out_is_ds     (out_is_ds),
    .out_is_branch (out_is_branch),
    .flush         (flush),
    .count         (count)
  );

  always #5 clk = ~clk;

  // Clears queue state (including the delay-slot tracker) between scenarios.
  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
    n_checks++; if (out_is_ds !== 1'b0) begin n_fail++; $display("FAIL reset_is_ds got %b exp 0", out_is_ds); end
    n_checks++; if (out_is_branch !== 1'b0) begin n_fail++; $display("FAIL reset_is_branch got %b exp 0", out_is_branch); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_instr = 32'h1000_0000; in_pc = 32'hBFC0_0000;
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_out_valid got %b exp 1", out_valid); end
    n_checks++; if (out_instr !== 32'h1000_0000) begin n_fail++; $display("FAIL single_instr got %h exp 10000000", out_instr); end
    n_checks++; if (out_pc_plus_8 !== 32'hBFC0_0008) begin n_fail++; $display("FAIL single_pc8 got %h exp bfc00008", out_pc_plus_8); end
    n_checks++; if (out_is_ds !== 1'b0) begin n_fail++; $display("FAIL single_is_ds got %b exp 0", out_is_ds); end
    n_checks++; if (out_is_branch !== 1'b1) begin n_fail++; $display("FAIL single_is_branch got %b exp 1", out_is_branch); end
    n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL single_count got %0d exp 1", count); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL single_drain_count got %0d exp 0", count); end
    do_flush();
  endtask

  task automatic test_delay_slot();
    in_valid = 1'b1; in_instr = I_BEQ; in_pc = 32'h0000_0100;
    @(negedge clk);
    in_instr = I_ADDU; in_pc = 32'h0000_0104;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL ds_count got %0d exp 2", count); end
    n_checks++; if (out_pc !== 32'h0000_0100) begin n_fail++; $display("FAIL ds_beq_pc got %h exp 00000100", out_pc); end
    n_checks++; if (out_is_branch !== 1'b1) begin n_fail++; $display("FAIL ds_beq_is_branch got %b exp 1", out_is_branch); end
    n_checks++; if (out_is_ds !== 1'b0) begin n_fail++; $display("FAIL ds_beq_is_ds got %b exp 0", out_is_ds); end
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (out_instr !== I_ADDU) begin n_fail++; $display("FAIL ds_addu_instr got %h exp %h", out_instr, I_ADDU); end
    n_checks++; if (out_is_ds !== 1'b1) begin n_fail++; $display("FAIL ds_addu_is_ds got %b exp 1", out_is_ds); end
    n_checks++; if (out_is_branch !== 1'b0) begin n_fail++; $display("FAIL ds_addu_is_branch got %b exp 0", out_is_branch); end
    n_checks++; if (out_pc_plus_8 !== 32'h0000_010C) begin n_fail++; $display("FAIL ds_addu_pc8 got %h exp 0000010c", out_pc_plus_8); end
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ds_drain_valid got %b exp 0", out_valid); end
    do_flush();
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_instr = I_ADDU; in_pc = 32'h200 + 32'(i * 4);
      @(negedge clk);
    end
    // A branch offered while full must neither enter nor update the slot tracker.
    in_instr = I_J; in_pc = 32'h0000_0210;
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_count got %0d exp 4", count); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready got %b exp 0", in_ready); end
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_no_ready_through got %b exp 0", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL full_deq_count got %0d exp 3", count); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_back got %b exp 1", in_ready); end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (out_pc !== 32'h204 + 32'(i * 4)) begin
        n_fail++; $display("FAIL full_drain_pc%0d got %h exp %h", i, out_pc, 32'h204 + 32'(i * 4));
      end
      @(negedge clk);
    end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL full_drain_empty got %b exp 0", out_valid); end
    // Empty with out_ready held high: in_valid only enqueues.
    in_valid = 1'b1; in_instr = I_ADDU; in_pc = 32'h0000_0300;
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL empty_enq_count got %0d exp 1", count); end
    n_checks++; if (out_pc !== 32'h0000_0300) begin n_fail++; $display("FAIL empty_enq_pc got %h exp 00000300", out_pc); end
    n_checks++; if (out_is_ds !== 1'b0) begin n_fail++; $display("FAIL blocked_br_last_br got %b exp 0", out_is_ds); end
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL empty_drain_count got %0d exp 0", count); end
  endtask

  task automatic test_flush();
    in_valid = 1'b1; in_instr = I_JR; in_pc = 32'h0000_0400;
    @(negedge clk);
    n_checks++; if (out_is_branch !== 1'b1) begin n_fail++; $display("FAIL flush_jr_branch got %b exp 1", out_is_branch); end
    flush = 1'b1; in_instr = I_ADDU; in_pc = 32'h0000_0404;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL flush_count got %0d exp 0", count); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b exp 0", out_valid); end
    in_valid = 1'b1; in_instr = I_ADDU; in_pc = 32'h0000_0408;
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (out_pc !== 32'h0000_0408) begin n_fail++; $display("FAIL flush_next_pc got %h exp 00000408", out_pc); end
    n_checks++; if (out_is_ds !== 1'b0) begin n_fail++; $display("FAIL flush_next_is_ds got %b exp 0", out_is_ds); end
    n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL flush_next_count got %0d exp 1", count); end
    do_flush();
  endtask

  task automatic test_predecode();
    logic [31:0] vec_instr [10];
    logic        vec_br    [10];
    vec_instr = '{32'h1400_0000, 32'h1800_0000, 32'h1C00_0000, 32'h0411_0000, I_J,
                  I_JAL, 32'h0040_F809, I_ADDU, 32'h0000_000A, 32'h2000_0008};
    vec_br    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_instr = vec_instr[i]; in_pc = 32'h500 + 32'(i * 4);
      @(negedge clk);
      in_valid = 1'b0;
      n_checks++;
      if (out_is_branch !== vec_br[i]) begin
        n_fail++; $display("FAIL predecode_%h got %b exp %b", vec_instr[i], out_is_branch, vec_br[i]);
      end
      do_flush();
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; out_ready = 1'b1;
      in_instr = (i == 3) ? I_JAL : I_ADDU;
      in_pc = 32'(i * 4);
      @(negedge clk);
      n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL stream_count%0d got %0d exp 1", i, count); end
      n_checks++; if (out_pc !== 32'(i * 4)) begin n_fail++; $display("FAIL stream_pc%0d got %h exp %h", i, out_pc, 32'(i * 4)); end
      n_checks++; if (out_is_ds !== (i == 4)) begin n_fail++; $display("FAIL stream_is_ds%0d got %b exp %b", i, out_is_ds, (i == 4)); end
      n_checks++; if (out_is_branch !== (i == 3)) begin n_fail++; $display("FAIL stream_is_br%0d got %b exp %b", i, out_is_branch, (i == 3)); end
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL stream_end_count got %0d exp 0", count); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_instr = I_ADDU; in_pc = 32'h600 + 32'(i * 4);
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL arst_pre_count got %0d exp 3", count); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid got %b exp 0", out_valid); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL arst_count got %0d exp 0", count); end
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL arst_post_ready got %b exp 1", in_ready); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL arst_post_count got %0d exp 0", count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_delay_slot();
    test_full();
    test_flush();
    test_predecode();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
